// File: rtl/turn_signal_input_conditioner_pkg.sv
// Shared constants for the turn-signal input conditioner: request codes,
// request-vector bit positions and the default debounce length.
package turn_sig_pkg;

    localparam logic [2:0] SIG_IDLE  = 3'b000;
    localparam logic [2:0] SIG_LEFT  = 3'b100;
    localparam logic [2:0] SIG_HAZ   = 3'b010;
    localparam logic [2:0] SIG_RIGHT = 3'b001;

    localparam int IDX_LEFT  = 2;
    localparam int IDX_HAZ   = 1;
    localparam int IDX_RIGHT = 0;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/turn_signal_input_conditioner_sw_debounce.sv
// One switch channel: two-flop synchronizer followed by a hold-time debouncer.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES clocks.
module sw_debounce
    import turn_sig_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = '0;
        // Any return to the accepted level drops the count back to zero.
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = deb_q;

endmodule

// File: rtl/turn_signal_input_conditioner.sv
// Conditions the raw dash switches into a legal {left, haz, right} request
// and enable for the turn-signal sequencer, plus a one-cycle change strobe.
module turn_signal_input_conditioner
    import turn_sig_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sw_left,
    input  logic       sw_haz,
    input  logic       sw_right,
    input  logic       sw_en,
    output logic [2:0] sig_out,
    output logic       en_out,
    output logic       chg
);

    logic [2:0] deb_req;
    logic       deb_en;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_left (
        .clk(clk), .clr(clr), .raw(sw_left), .level(deb_req[IDX_LEFT])
    );
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_haz (
        .clk(clk), .clr(clr), .raw(sw_haz), .level(deb_req[IDX_HAZ])
    );
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_right (
        .clk(clk), .clr(clr), .raw(sw_right), .level(deb_req[IDX_RIGHT])
    );
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_en (
        .clk(clk), .clr(clr), .raw(sw_en), .level(deb_en)
    );

    logic [2:0] sig_q, sig_d;
    logic       en_q, en_d;
    logic       chg_q, chg_d;

    always_comb begin
        // Left and right together is treated as a hazard request.
        if (deb_req[IDX_HAZ] || (deb_req[IDX_LEFT] && deb_req[IDX_RIGHT])) begin
            sig_d = SIG_HAZ;
        end else if (deb_req[IDX_LEFT]) begin
            sig_d = SIG_LEFT;
        end else if (deb_req[IDX_RIGHT]) begin
            sig_d = SIG_RIGHT;
        end else begin
            sig_d = SIG_IDLE;
        end
        en_d  = deb_en;
        chg_d = (sig_d != sig_q);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            sig_q <= SIG_IDLE;
            en_q  <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
            en_q  <= en_d;
            chg_q <= chg_d;
        end
    end

    assign sig_out = sig_q;
    assign en_out  = en_q;
    assign chg     = chg_q;

endmodule
